hit_receiver: RTL and testbench
===============================

Name: hit_receiver

Overview:
- Victim-side end of the projectile hit interface: consumes the `hit_player` level from a projectile block and applies its effects to one player.
- Effects: damage, invulnerability window, knockback stepping, KO detection and revive.
- One instance per player. Outputs feed the health bar, the sprite renderer (`flash`) and the player movement block (knockback steps).

Parameters:
- MAX_HEALTH, 100: health after reset and after revive.
- DAMAGE, 10: health removed per accepted hit.
- INVULN_TICKS, 20: invulnerability length in 20 Hz ticks (1 s). Must exceed the projectile hit-hold time.
- KNOCK_TICKS, 6: number of knockback steps issued per accepted hit.
- MIN_X, 4: leftmost x the player may be knocked to.
- MAX_X, 91: rightmost x the player may be knocked to.

Ports:
- clk, input, 1: system clock (100 MHz).
- reset, input, 1: asynchronous, active-high reset.
- tick_20hz, input, 1: 20 Hz square wave from the codebase divider, same clock domain. The block detects its rising edge internally.
- hit_in, input, 1: hit level from the projectile block. May stay high for millions of cycles.
- bullet_x, input, 7: projectile x at the time of the hit.
- player_x, input, 7: current player x, owned by the movement block.
- revive, input, 1: level; acted on only while in KO.
- health, output, 7: current health, 0..MAX_HEALTH.
- ko, output, 1: player knocked out.
- invuln, output, 1: invulnerability window active.
- flash, output, 1: sprite blink enable.
- hit_ack, output, 1: one-cycle pulse when damage is applied.
- knock_step, output, 1: one-cycle pulse requesting a 1 px move.
- knock_dir, output, 1: move direction; 1 = +x (right), 0 = -x (left).

Behaviour:
- Edge detection
  - `hit_prev` and `tick_prev` are registered copies of their inputs.
  - hit_rise = hit_in & ~hit_prev; tick_rise = tick_20hz & ~tick_prev.
  - hit_prev resets to 1 and tick_prev resets to 0. A hit_in already high at reset release is therefore NOT a hit.
  - Only rising edges of hit_in count. A held level never re-triggers, including after invuln expires.
- Reset (asynchronous): health=MAX_HEALTH, state=ALIVE, ko=0, invuln=0, flash=0, hit_ack=0, knock_step=0, knock_dir=0, all counters 0.
- States
  - ALIVE: normal play.
  - KO: knocked out; ko=1 in this state only.
- ALIVE, accepted hit (hit_rise && invuln==0)
  - Registered on the same edge, so visible 1 clk after hit_in is first sampled high.
  - health = health - DAMAGE when health > DAMAGE; otherwise 0 (saturating, no wrap).
  - hit_ack=1 for exactly 1 clk.
  - Invuln counter loaded with INVULN_TICKS; invuln=1.
  - Knock counter loaded with KNOCK_TICKS.
  - knock_dir latched: 1 if bullet_x <= player_x, else 0.
  - If the new health is 0: go to KO. In that case no invuln and no knockback are started.
- ALIVE, rejected hit: hit_rise while invuln==1 has no effect and produces no hit_ack.
- ALIVE, on each tick_rise
  - Invuln counter:
    - Decrements if nonzero.
    - invuln=0 on the edge the counter reaches 0.
    - flash toggles on each tick_rise while invuln; flash is forced to 0 when invuln=0.
  - Knock counter:
    - If nonzero it decrements, and knock_step pulses 1 clk.
    - The pulse is suppressed (counter still decrements) when knock_dir=0 && player_x<=MIN_X, or knock_dir=1 && player_x>=MAX_X.
- Simultaneous accepted hit_rise and tick_rise: counters load and the tick is not applied to them. knock_step=0 that cycle.
- A new accepted hit after invuln expires while knockback is still active: reloads the knock counter and re-latches knock_dir.
- KO
  - Hits ignored; hit_ack, knock_step, invuln and flash all 0; knock counter cleared.
  - revive=1 → on the next edge: health=MAX_HEALTH, ko=0, state ALIVE, invuln counter loaded with INVULN_TICKS (spawn protection).
  - revive while ALIVE is ignored.
- Reset mid-operation clears everything immediately, regardless of state or counters.
- All outputs are registered; no combinational paths from inputs to outputs.

Test Plan:
1. Reset held high with hit_in=1, then released with hit_in still high for 500 clks → health=100, no hit_ack. Then drop hit_in and raise it → hit_ack 1 clk, health=90, invuln=1.
2. Accepted hit with bullet_x=30, player_x=40 → knock_dir=1, exactly 6 knock_step pulses, one on each of the next 6 tick_rise. invuln falls after 20 ticks. flash toggles while invuln and is 0 after.
3. Second hit_rise 5 ticks after the first → ignored, health stays 90, no hit_ack. Hit_rise after invuln ends → health=80.
4. bullet_x=50, player_x=5, MIN_X=4 → first step issued, then player_x=4. Remaining 5 ticks issue no knock_step, while the knock counter still expires after 6 ticks total.
5. Health 10 and an accepted hit → health=0, ko=1, invuln=0, no knock_step. Further hits ignored. revive=1 → health=100, ko=0, invuln=1 for 20 ticks.
6. Health 5 and an accepted hit → health=0 (saturates, no wrap), ko=1. Coincident hit_rise and tick_rise on an earlier hit → counters loaded, no knock_step that cycle.

Source files
------------

// File: rtl/hit_receiver.sv
// hit_receiver
//   Victim-side end of the projectile hit interface. It takes the hit level
//   from a projectile block and applies the hit to one player: damage,
//   an invulnerability window, knockback stepping, knockout and revive.
//
// Ports
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   tick_20hz  : 20 Hz square wave in the clk domain; its rising edge is detected here
//   hit_in     : hit level from the projectile block; only its rising edge counts
//   bullet_x   : projectile x when the hit occurs
//   player_x   : current player x, owned by the movement block
//   revive     : revive request level; acted on only while knocked out
//   health     : current health, 0..MAX_HEALTH
//   ko         : player knocked out
//   invuln     : invulnerability window active
//   flash      : sprite blink enable
//   hit_ack    : one-cycle pulse when damage is applied
//   knock_step : one-cycle pulse requesting a 1 px move
//   knock_dir  : knockback direction, 1 = +x, 0 = -x
//
// State table
//   ST_ALIVE | normal play; hits, invulnerability and knockback are processed
//   ST_KO    | knocked out; hits are ignored and the block waits for revive

module hit_receiver #(
    parameter int MAX_HEALTH   = 100,
    parameter int DAMAGE       = 10,
    parameter int INVULN_TICKS = 20,
    parameter int KNOCK_TICKS  = 6,
    parameter int MIN_X        = 4,
    parameter int MAX_X        = 91
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_20hz,
    input  logic       hit_in,
    input  logic [6:0] bullet_x,
    input  logic [6:0] player_x,
    input  logic       revive,
    output logic [6:0] health,
    output logic       ko,
    output logic       invuln,
    output logic       flash,
    output logic       hit_ack,
    output logic       knock_step,
    output logic       knock_dir
);

    localparam int INV_W = $clog2(INVULN_TICKS + 1);
    localparam int KNK_W = $clog2(KNOCK_TICKS + 1);

    localparam logic [6:0]       C_MAX_HEALTH = 7'(MAX_HEALTH);
    localparam logic [6:0]       C_DAMAGE     = 7'(DAMAGE);
    localparam logic [6:0]       C_MIN_X      = 7'(MIN_X);
    localparam logic [6:0]       C_MAX_X      = 7'(MAX_X);
    localparam logic [INV_W-1:0] C_INV_LOAD   = INV_W'(INVULN_TICKS);
    localparam logic [KNK_W-1:0] C_KNK_LOAD   = KNK_W'(KNOCK_TICKS);
    localparam logic [INV_W-1:0] C_INV_ONE    = INV_W'(1);
    localparam logic [KNK_W-1:0] C_KNK_ONE    = KNK_W'(1);

    typedef enum logic {
        ST_ALIVE = 1'b0,
        ST_KO    = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_hit_prev;
    logic             r_tick_prev;
    logic [INV_W-1:0] r_inv_cnt;
    logic [KNK_W-1:0] r_knock_cnt;

    logic       w_hit_rise;
    logic       w_tick_rise;
    logic       w_hit_accept;
    logic       w_knock_block;
    logic [6:0] w_health_next;

    assign w_hit_rise   = hit_in & ~r_hit_prev;
    assign w_tick_rise  = tick_20hz & ~r_tick_prev;
    assign w_hit_accept = w_hit_rise & ~invuln;

    // Saturating subtract: health never wraps below zero.
    assign w_health_next = (health > C_DAMAGE) ? (health - C_DAMAGE) : 7'd0;

    // Knockback is not issued past the arena edge the player is being pushed toward.
    assign w_knock_block = knock_dir ? (player_x >= C_MAX_X) : (player_x <= C_MIN_X);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // hit_prev starts high so a level already present at release is not a hit.
            r_hit_prev  <= 1'b1;
            r_tick_prev <= 1'b0;
            r_state     <= ST_ALIVE;
            r_inv_cnt   <= '0;
            r_knock_cnt <= '0;
            health      <= C_MAX_HEALTH;
            ko          <= 1'b0;
            invuln      <= 1'b0;
            flash       <= 1'b0;
            hit_ack     <= 1'b0;
            knock_step  <= 1'b0;
            knock_dir   <= 1'b0;
        end else begin
            r_hit_prev  <= hit_in;
            r_tick_prev <= tick_20hz;
            hit_ack     <= 1'b0;
            knock_step  <= 1'b0;

            case (r_state)
                ST_ALIVE: begin
                    if (w_hit_accept) begin
                        // A coincident tick is dropped: the counters load instead.
                        health    <= w_health_next;
                        hit_ack   <= 1'b1;
                        knock_dir <= (bullet_x <= player_x);
                        if (w_health_next == 7'd0) begin
                            r_state     <= ST_KO;
                            ko          <= 1'b1;
                            r_inv_cnt   <= '0;
                            r_knock_cnt <= '0;
                            invuln      <= 1'b0;
                            flash       <= 1'b0;
                        end else begin
                            r_inv_cnt   <= C_INV_LOAD;
                            r_knock_cnt <= C_KNK_LOAD;
                            invuln      <= 1'b1;
                        end
                    end else if (w_tick_rise) begin
                        if (r_inv_cnt != '0) begin
                            r_inv_cnt <= r_inv_cnt - C_INV_ONE;
                            if (r_inv_cnt == C_INV_ONE) begin
                                invuln <= 1'b0;
                                flash  <= 1'b0;
                            end else begin
                                flash  <= ~flash;
                            end
                        end
                        if (r_knock_cnt != '0) begin
                            // The counter runs down even when the step is blocked.
                            r_knock_cnt <= r_knock_cnt - C_KNK_ONE;
                            knock_step  <= ~w_knock_block;
                        end
                    end
                end

                ST_KO: begin
                    r_knock_cnt <= '0;
                    invuln      <= 1'b0;
                    flash       <= 1'b0;
                    if (revive) begin
                        r_state   <= ST_ALIVE;
                        health    <= C_MAX_HEALTH;
                        ko        <= 1'b0;
                        r_inv_cnt <= C_INV_LOAD;
                        invuln    <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_ALIVE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hit_receiver.sv
module tb_hit_receiver;

    typedef struct {
        int health;
        int dir;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_20hz;
    logic       hit_in;
    logic [6:0] bullet_x;
    logic [6:0] player_x;
    logic       revive;

    logic [6:0] health;
    logic       ko, invuln, flash, hit_ack, knock_step, knock_dir;

    logic [6:0] b_health;
    logic       b_ko, b_invuln, b_flash, b_hit_ack, b_knock_step, b_knock_dir;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_knock  = 0;
    int   n_ack    = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hit_receiver dut (
        .clk        (clk),
        .reset      (reset),
        .tick_20hz  (tick_20hz),
        .hit_in     (hit_in),
        .bullet_x   (bullet_x),
        .player_x   (player_x),
        .revive     (revive),
        .health     (health),
        .ko         (ko),
        .invuln     (invuln),
        .flash      (flash),
        .hit_ack    (hit_ack),
        .knock_step (knock_step),
        .knock_dir  (knock_dir)
    );

    // Second instance with DAMAGE=19 reaches health 5 and must saturate to 0.
    hit_receiver #(.DAMAGE(19)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .tick_20hz  (tick_20hz),
        .hit_in     (hit_in),
        .bullet_x   (bullet_x),
        .player_x   (player_x),
        .revive     (revive),
        .health     (b_health),
        .ko         (b_ko),
        .invuln     (b_invuln),
        .flash      (b_flash),
        .hit_ack    (b_hit_ack),
        .knock_step (b_knock_step),
        .knock_dir  (b_knock_dir)
    );

    task automatic check(input string tag, input int obs, input int exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // One clock; sampled 1 ns after the edge. Every hit_ack pops the scoreboard.
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        if (knock_step) n_knock++;
        if (hit_ack) begin
            n_ack++;
            check("ack_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ack_health", health, e.health);
                if (e.health != 0) check("ack_dir", knock_dir, e.dir);
            end
        end
    endtask

    task automatic do_tick();
        tick_20hz = 1'b1;
        cyc();
        tick_20hz = 1'b0;
        cyc();
    endtask

    task automatic do_hit(input logic [6:0] bx, input logic [6:0] px,
                          input bit push, input int eh, input int ed);
        exp_t e;
        bullet_x = bx;
        player_x = px;
        if (push) begin
            e.health = eh;
            e.dir    = ed;
            exp_q.push_back(e);
        end
        hit_in = 1'b1;
        cyc();
        hit_in = 1'b0;
        cyc();
    endtask

    // Ticks numbered from the last invuln load; window is 20 ticks, flash toggles inside it.
    task automatic run_ticks(input int first, input int last, input bit chk_knock);
        for (int k = first; k <= last; k++) begin
            do_tick();
            check("invuln_tick", invuln, (k < 20) ? 1 : 0);
            check("flash_tick", flash, (k < 20) ? (k % 2) : 0);
            if (chk_knock) check("knock_count", n_knock, (k < 6) ? k : 6);
        end
    endtask

    initial begin
        exp_t e;
        reset     = 1'b1;
        hit_in    = 1'b1;
        tick_20hz = 1'b0;
        revive    = 1'b0;
        bullet_x  = 7'd30;
        player_x  = 7'd40;

        // Reset state with hit_in held high
        repeat (3) cyc();
        check("rst_health", health, 100);
        check("rst_ko", ko, 0);
        check("rst_invuln", invuln, 0);
        check("rst_flash", flash, 0);
        check("rst_ack", hit_ack, 0);
        check("rst_knock", knock_step, 0);
        reset = 1'b0;
        repeat (500) cyc();
        check("held_no_ack", n_ack, 0);
        check("held_health", health, 100);

        // First real hit: bullet left of player, push right
        hit_in = 1'b0;
        cyc();
        e.health = 90;
        e.dir    = 1;
        exp_q.push_back(e);
        hit_in = 1'b1;
        cyc();
        check("hit1_ack_count", n_ack, 1);
        check("hit1_invuln", invuln, 1);
        check("hit1_dir", knock_dir, 1);
        cyc();
        check("hit1_ack_1clk", hit_ack, 0);
        hit_in = 1'b0;
        cyc();

        // Knockback steps, flash, invuln expiry; rejected hit after tick 5
        n_knock = 0;
        run_ticks(1, 5, 1);
        do_hit(7'd30, 7'd40, 0, 0, 0);
        check("reject_health", health, 90);
        check("reject_no_ack", n_ack, 1);
        run_ticks(6, 20, 1);

        // Hit after invuln ends, knocked left into MIN_X
        do_hit(7'd50, 7'd5, 1, 80, 0);
        check("hit2_health", health, 80);
        n_knock = 0;
        run_ticks(1, 1, 0);
        check("edge_first_step", n_knock, 1);
        player_x = 7'd4;
        run_ticks(2, 6, 0);
        check("edge_blocked", n_knock, 1);
        player_x = 7'd40;
        run_ticks(7, 7, 0);
        check("knock_expired", n_knock, 1);
        run_ticks(8, 20, 0);

        // Wear health down; dut_b (DAMAGE=19) saturates from 5 to 0
        for (int h = 70; h >= 10; h -= 10) begin
            do_hit(7'd30, 7'd40, 1, h, 1);
            check("walk_health", health, h);
            if (h == 50) check("b_health_5", b_health, 5);
            if (h == 40) begin
                check("b_sat_health", b_health, 0);
                check("b_sat_ko", b_ko, 1);
            end
            run_ticks(1, 20, 0);
        end

        // Lethal hit from 10
        do_hit(7'd30, 7'd40, 1, 0, 1);
        check("ko_health", health, 0);
        check("ko_flag", ko, 1);
        check("ko_invuln", invuln, 0);
        check("ko_flash", flash, 0);
        n_knock = 0;
        repeat (3) do_tick();
        check("ko_no_knock", n_knock, 0);
        check("ko_stays", ko, 1);
        do_hit(7'd30, 7'd40, 0, 0, 0);
        check("ko_hit_ignored", health, 0);

        // Revive with spawn protection
        revive = 1'b1;
        cyc();
        revive = 1'b0;
        check("rev_health", health, 100);
        check("rev_ko", ko, 0);
        check("rev_invuln", invuln, 1);
        run_ticks(1, 20, 0);

        // Coincident hit rise and tick rise: tick not applied to fresh counters
        n_knock  = 0;
        bullet_x = 7'd30;
        player_x = 7'd40;
        e.health = 90;
        e.dir    = 1;
        exp_q.push_back(e);
        hit_in    = 1'b1;
        tick_20hz = 1'b1;
        cyc();
        check("coinc_no_step", n_knock, 0);
        check("coinc_invuln", invuln, 1);
        hit_in    = 1'b0;
        tick_20hz = 1'b0;
        cyc();
        run_ticks(1, 20, 1);

        // Asynchronous reset mid-knockback
        do_hit(7'd30, 7'd40, 1, 80, 1);
        do_tick();
        #3;
        reset = 1'b1;
        #1;
        check("async_health", health, 100);
        check("async_invuln", invuln, 0);
        check("async_knock_dir", knock_dir, 0);
        check("async_ko", ko, 0);
        check("b_rst_health", b_health, 100);
        check("b_rst_flags", {b_ko, b_invuln, b_flash, b_hit_ack, b_knock_step, b_knock_dir}, 0);
        cyc();
        reset = 1'b0;
        cyc();
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
